// File: rtl/addsub_accumulator_pkg.sv
// Shared types and the reference 4-bit add/sub step for the burst accumulator.
package addsub_pkg;

    typedef enum logic {ACCUM, HOLD} acc_state_t;

    localparam int ADDSUB_W = 4;
    localparam logic [ADDSUB_W-1:0] SAT_POS = {1'b0, {(ADDSUB_W-1){1'b1}}};
    localparam logic [ADDSUB_W-1:0] SAT_NEG = {1'b1, {(ADDSUB_W-1){1'b0}}};

    // Returns {carry, ovf, sum}; b is inverted with a +1 carry-in for subtraction.
    function automatic logic [ADDSUB_W+1:0] addsub_step(input logic [ADDSUB_W-1:0] acc,
                                                        input logic [ADDSUB_W-1:0] b,
                                                        input logic sub);
        logic [ADDSUB_W-1:0] bx;
        logic [ADDSUB_W:0]   r;
        logic                v;
        bx = b ^ {ADDSUB_W{sub}};
        r  = {1'b0, acc} + {1'b0, bx} + {{ADDSUB_W{1'b0}}, sub};
        v  = (acc[ADDSUB_W-1] == bx[ADDSUB_W-1]) && (r[ADDSUB_W-1] != acc[ADDSUB_W-1]);
        return {r[ADDSUB_W], v, r[ADDSUB_W-1:0]};
    endfunction

endpackage

// File: rtl/addsub_accumulator_core.sv
// Combinational WIDTH-bit add/sub with carry-out and signed overflow; the slot where
// a gate-level ripple adder can replace the behavioural one for WIDTH=4.
module acc_addsub_core
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    generate
        if (WIDTH == ADDSUB_W) begin : g_pkg
            logic [ADDSUB_W+1:0] r;
            assign r = addsub_step(a_i, b_i, sub_i);
            assign {cout_o, ovf_o, sum_o} = r;
        end else begin : g_gen
            logic [WIDTH-1:0] bx;
            logic [WIDTH:0]   r;
            assign bx     = b_i ^ {WIDTH{sub_i}};
            assign r      = {1'b0, a_i} + {1'b0, bx} + {{WIDTH{1'b0}}, sub_i};
            assign sum_o  = r[WIDTH-1:0];
            assign cout_o = r[WIDTH];
            assign ovf_o  = (a_i[WIDTH-1] == bx[WIDTH-1]) && (r[WIDTH-1] != a_i[WIDTH-1]);
        end
    endgenerate

endmodule

// File: rtl/addsub_accumulator.sv
// Burst accumulator: folds valid/ready beats into acc +/- data and presents the result
// with carry/sticky-overflow. Define ADDSUB_SAT_EN to clamp on overflow instead of wrapping.
module addsub_accumulator
    import addsub_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_sub,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_sum,
    output logic               out_carry,
    output logic               out_ovf,
    output logic [COUNT_W-1:0] out_count
);

    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
    localparam logic [WIDTH-1:0]   LIM_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]   LIM_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    acc_state_t         state_q;
    logic [WIDTH-1:0]   acc_q, acc_d, sum;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               ovf_q, carry_q, in_ready_q, out_valid_q;
    logic               cout, ovf;

    acc_addsub_core #(.WIDTH(WIDTH)) u_core (
        .a_i    (acc_q),
        .b_i    (in_data),
        .sub_i  (in_sub),
        .sum_o  (sum),
        .cout_o (cout),
        .ovf_o  (ovf)
    );

    // Overflowed beats clamp toward the operands' common sign.
`ifdef ADDSUB_SAT_EN
    assign acc_d = ovf ? (acc_q[WIDTH-1] ? LIM_NEG : LIM_POS) : sum;
`else
    assign acc_d = sum;
    logic unused_lim;
    assign unused_lim = ^{LIM_POS, LIM_NEG};
`endif
    assign count_d = count_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid && in_ready_q) begin
                        acc_q   <= acc_d;
                        count_q <= count_d;
                        carry_q <= cout;
                        ovf_q   <= ovf_q | ovf;
                        if (in_last || count_d == CNT_MAX) begin
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        acc_q       <= '0;
                        count_q     <= '0;
                        carry_q     <= 1'b0;
                        ovf_q       <= 1'b0;
                        state_q     <= ACCUM;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign out_carry = carry_q;
    assign out_ovf   = ovf_q;
    assign out_count = count_q;

endmodule
